// File: rtl/ahb_obi_pkg.sv
// Shared encodings for the AHB-slave to OBI-master adapter: AHB transfer
// types and sizes, the adapter FSM states, and byte-enable/legality helpers.
package ahb_obi_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_e;

    // Byte lanes touched by a transfer; oversize transfers fall back to all lanes.
    function automatic logic [3:0] be_decode(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = 4'b0011 << {a[1], 1'b0};
            default:    be = 4'hF;
        endcase
        return be;
    endfunction

    // Transfers wider than a word, or not naturally aligned, cannot be mapped
    // onto a single OBI word access.
    function automatic logic xfer_bad(input logic [2:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = a[0];
            HSIZE_WORD: bad = (a != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ahbs2obim_adapter.sv
// AHB-Lite slave to OBI master bridge. One OBI transaction in flight at a
// time; misaligned/oversize AHB transfers get a two-cycle ERROR response.
import ahb_obi_pkg::*;

module ahbs2obim_adapter #(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        hclk,
    input  logic        hreset_n,
    // AHB slave side
    input  logic        hsel_s,
    input  logic [31:0] haddr_s,
    input  logic [1:0]  htrans_s,
    input  logic        hwrite_s,
    input  logic [2:0]  hsize_s,
    input  logic [31:0] hwdata_s,
    input  logic        hready_s,
    output logic        hreadyout_s,
    output logic        hresp_s,
    output logic [31:0] hrdata_s,
    // OBI master side
    output logic        obi_req_o,
    output logic        obi_we_o,
    output logic [31:0] obi_addr_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic        obi_err_i,
    input  logic [31:0] obi_rdata_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic        req_q, hrdy_q, hresp_q;

    logic active_trans, capture, accept, bad, rsp_ok, rsp_err;
    state_e capture_state;

    // SEQ is handled exactly like NONSEQ: every access is a standalone OBI word.
    assign active_trans = (htrans_s == HTRANS_NONSEQ) || (htrans_s == HTRANS_SEQ);
    assign capture      = hsel_s & hready_s & active_trans;
    assign rsp_ok       = (state_q == RESP) & obi_rvalid_i & ~obi_err_i;
    assign rsp_err      = (state_q == RESP) & obi_rvalid_i &  obi_err_i;
    // A new address phase can only be taken where the slave drives HREADYOUT high.
    assign accept       = capture & ((state_q == IDLE) | (state_q == ERR2) | rsp_ok);
    assign bad          = ERR_ON_MISALIGN & xfer_bad(hsize_s, haddr_s[1:0]);
    assign capture_state = bad ? ERR1 : REQ;

    // Next-state decode for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = capture_state;
            REQ:  if (obi_gnt_i) state_d = RESP;
            RESP: begin
                if (rsp_err)     state_d = ERR1;
                else if (rsp_ok) state_d = accept ? capture_state : IDLE;
            end
            ERR1: state_d = ERR2;
            ERR2: state_d = accept ? capture_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            hrdy_q  <= 1'b1;
            hresp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == REQ);
            hrdy_q  <= (state_d == IDLE) || (state_d == ERR2);
            hresp_q <= (state_d == ERR1) || (state_d == ERR2);
        end
    end

    // Address-phase capture; held untouched until the next accepted transfer.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            addr_q <= 32'h0;
            we_q   <= 1'b0;
            size_q <= 3'd0;
        end else if (accept) begin
            addr_q <= haddr_s;
            we_q   <= hwrite_s;
            size_q <= hsize_s;
        end
    end

    // OBI request fields come straight from the captured phase, so they stay
    // stable for the whole REQ wait; write data is the live AHB data phase.
    assign obi_req_o   = req_q;
    assign obi_we_o    = we_q;
    assign obi_addr_o  = {addr_q[31:2], 2'b00};
    assign obi_be_o    = be_decode(size_q, addr_q[1:0]);
    assign obi_wdata_o = hwdata_s;

    // Completion is combinational on rvalid so a zero-wait slave gives 3 cycles.
    assign hreadyout_s = hrdy_q | rsp_ok;
    assign hresp_s     = hresp_q;
    assign hrdata_s    = ((state_q == RESP) && obi_rvalid_i) ? obi_rdata_i : 32'h0;

endmodule

// File: tb/tb_ahbs2obim_adapter.sv
// Self-checking bench for ahbs2obim_adapter: scenario tasks push expected
// transfer outcomes into a scoreboard queue and compare on completion.
module tb_ahbs2obim_adapter;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        hsel_s, hwrite_s, hready_s;
    logic [31:0] haddr_s, hwdata_s;
    logic [1:0]  htrans_s;
    logic [2:0]  hsize_s;
    logic        hreadyout_s, hresp_s;
    logic [31:0] hrdata_s;
    logic        obi_req_o, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic        obi_gnt_i, obi_rvalid_i, obi_err_i;
    logic [31:0] obi_rdata_i;

    always #5 hclk = ~hclk;

    // Single slave on the bus: bus HREADY is our own HREADYOUT.
    assign hready_s = hreadyout_s;

    ahbs2obim_adapter #(.ERR_ON_MISALIGN(1'b1)) dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .hsel_s(hsel_s), .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s),
        .hsize_s(hsize_s), .hwdata_s(hwdata_s), .hready_s(hready_s),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
        .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_addr_o(obi_addr_o),
        .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_err_i(obi_err_i),
        .obi_rdata_i(obi_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rdata;
        logic        resp;
        logic        req;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int tests_run = 0;
    int tests_failed = 0;

    // Observations collected by do_xfer for the most recent transfer
    logic        o_done, o_req, o_first_req, o_we, o_stable, o_err1, o_resp;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    int          o_cycles;

    function automatic exp_t mk(input logic [31:0] a, input logic [3:0] be, input logic we,
                                input logic [31:0] rd, input logic resp, input logic req, input int cyc);
        exp_t e;
        e.addr = a; e.be = be; e.we = we; e.rdata = rd;
        e.resp = resp; e.req = req; e.cycles = cyc;
        return e;
    endfunction

    // Drives one AHB transfer (unless its address phase was already presented
    // by the previous call) and plays an OBI slave: grant after gwait cycles,
    // rvalid one cycle later. Optionally presents a chained address phase in
    // the completion cycle. Entered and left at #1 after a rising edge.
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                           input logic [1:0] tr, input logic [31:0] wd, input int gwait,
                           input logic e, input logic [31:0] rd, input logic pre,
                           input logic nv, input logic [31:0] na, input logic [2:0] nsz);
        int gcnt;
        logic granted;
        if (!pre) begin
            hsel_s = 1'b1; haddr_s = a; htrans_s = tr; hwrite_s = w; hsize_s = sz;
            @(posedge hclk); #1;
        end
        hsel_s = 1'b0; htrans_s = 2'b00; hwdata_s = wd;
        o_cycles = 1; gcnt = 0; granted = 1'b0; o_done = 1'b0; o_req = 1'b0;
        o_first_req = 1'b0; o_stable = 1'b1; o_err1 = 1'b0; o_resp = 1'b0; o_rdata = 32'h0;
        o_addr = 32'h0; o_be = 4'h0; o_we = 1'b0; o_wdata = 32'h0;
        while (!o_done && o_cycles < 40) begin
            o_cycles++;
            obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = 32'h0;
            if (granted) begin
                obi_rvalid_i = 1'b1; obi_err_i = e; obi_rdata_i = rd; granted = 1'b0;
            end else if (obi_req_o) begin
                if (!o_req) begin
                    o_addr = obi_addr_o; o_be = obi_be_o; o_we = obi_we_o; o_wdata = obi_wdata_o;
                    if (o_cycles == 2) o_first_req = 1'b1;
                end else if (obi_addr_o !== o_addr || obi_be_o !== o_be ||
                             obi_we_o !== o_we || obi_wdata_o !== o_wdata) begin
                    o_stable = 1'b0;
                end
                o_req = 1'b1;
                if (gcnt == gwait) begin obi_gnt_i = 1'b1; granted = 1'b1; end
                gcnt++;
            end
            if (nv && ((obi_rvalid_i && !obi_err_i) || (hresp_s && hreadyout_s))) begin
                hsel_s = 1'b1; haddr_s = na; htrans_s = 2'b10; hwrite_s = 1'b0; hsize_s = nsz;
            end
            @(negedge hclk);
            if (hresp_s && !hreadyout_s) o_err1 = 1'b1;
            if (hreadyout_s) begin o_done = 1'b1; o_resp = hresp_s; o_rdata = hrdata_s; end
            @(posedge hclk); #1;
        end
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = 32'h0;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        hsel_s = 0; haddr_s = 0; htrans_s = 0; hwrite_s = 0; hsize_s = 0; hwdata_s = 0;
        obi_gnt_i = 0; obi_rvalid_i = 0; obi_err_i = 0; obi_rdata_i = 0;
        #12;
        tests_run++; if (obi_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset.req got=%b exp=0", obi_req_o); end
        tests_run++; if (hreadyout_s !== 1'b1) begin tests_failed++; $display("FAIL reset.hreadyout got=%b exp=1", hreadyout_s); end
        tests_run++; if (hresp_s !== 1'b0) begin tests_failed++; $display("FAIL reset.hresp got=%b exp=0", hresp_s); end
        tests_run++; if (hrdata_s !== 32'h0) begin tests_failed++; $display("FAIL reset.hrdata got=%h exp=0", hrdata_s); end
        tests_run++; if (obi_addr_o !== 32'h0 || obi_be_o !== 4'h1 || obi_we_o !== 1'b0) begin
            tests_failed++; $display("FAIL reset.regs addr=%h be=%h we=%b exp 0/1/0", obi_addr_o, obi_be_o, obi_we_o);
        end
        @(negedge hclk); hreset_n = 1'b1;
        @(posedge hclk); #1;
    endtask

    task automatic test_idle_busy();
        for (int i = 0; i < 2; i++) begin
            hsel_s = 1'b1; haddr_s = 32'h40; htrans_s = (i == 0) ? 2'b00 : 2'b01; hsize_s = 3'd2;
            @(negedge hclk);
            tests_run++; if (hreadyout_s !== 1'b1 || hresp_s !== 1'b0) begin
                tests_failed++; $display("FAIL idle_busy[%0d] hreadyout=%b hresp=%b exp 1/0", i, hreadyout_s, hresp_s);
            end
            @(posedge hclk); #1;
            tests_run++; if (obi_req_o !== 1'b0) begin tests_failed++; $display("FAIL idle_busy[%0d].req got=%b exp=0", i, obi_req_o); end
        end
        hsel_s = 1'b0; htrans_s = 2'b00;
    endtask

    task automatic test_word_read();
        exp_t e;
        sb.push_back(mk(32'h100, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 3));
        do_xfer(32'h100, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 3'd0);
        e = sb.pop_front();
        tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL word_read.timeout done=%b exp=1", o_done); end
        tests_run++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we) begin
            tests_failed++; $display("FAIL word_read.obi addr=%h be=%h we=%b exp %h/%h/%b", o_addr, o_be, o_we, e.addr, e.be, e.we);
        end
        tests_run++; if (o_rdata !== e.rdata) begin tests_failed++; $display("FAIL word_read.rdata got=%h exp=%h", o_rdata, e.rdata); end
        tests_run++; if (o_resp !== e.resp) begin tests_failed++; $display("FAIL word_read.resp got=%b exp=%b", o_resp, e.resp); end
        tests_run++; if (o_cycles !== e.cycles) begin tests_failed++; $display("FAIL word_read.latency got=%0d exp=%0d", o_cycles, e.cycles); end
    endtask

    task automatic test_byte_write();
        exp_t e;
        sb.push_back(mk(32'h200, 4'b1000, 1'b1, 32'h5A5A0000, 1'b0, 1'b1, 5));
        do_xfer(32'h203, 1'b1, 3'd0, 2'b11, 32'h11000000, 2, 1'b0, 32'h5A5A0000, 1'b0, 1'b0, 32'h0, 3'd0);
        e = sb.pop_front();
        tests_run++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we) begin
            tests_failed++; $display("FAIL byte_write.obi addr=%h be=%h we=%b exp %h/%h/%b", o_addr, o_be, o_we, e.addr, e.be, e.we);
        end
        tests_run++; if (o_wdata !== 32'h11000000 || o_stable !== 1'b1) begin
            tests_failed++; $display("FAIL byte_write.wdata got=%h stable=%b exp 11000000/1", o_wdata, o_stable);
        end
        tests_run++; if (o_resp !== e.resp || o_rdata !== e.rdata) begin
            tests_failed++; $display("FAIL byte_write.resp resp=%b rdata=%h exp %b/%h", o_resp, o_rdata, e.resp, e.rdata);
        end
        tests_run++; if (o_cycles !== e.cycles) begin tests_failed++; $display("FAIL byte_write.latency got=%0d exp=%0d", o_cycles, e.cycles); end
    endtask

    task automatic test_lanes();
        logic [31:0] ta [3];
        logic [2:0]  ts [3];
        logic [3:0]  tb [3];
        exp_t e;
        ta = '{32'h102, 32'h101, 32'h106};
        ts = '{3'd1, 3'd0, 3'd1};
        tb = '{4'b1100, 4'b0010, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk({ta[i][31:2], 2'b00}, tb[i], 1'b0, 32'h1000 + i, 1'b0, 1'b1, 3));
            do_xfer(ta[i], 1'b0, ts[i], 2'b10, 32'h0, 0, 1'b0, 32'h1000 + i, 1'b0, 1'b0, 32'h0, 3'd0);
            e = sb.pop_front();
            tests_run++; if (o_addr !== e.addr || o_be !== e.be || o_rdata !== e.rdata || o_cycles !== e.cycles) begin
                tests_failed++;
                $display("FAIL lanes[%0d] addr=%h be=%h rdata=%h cyc=%0d exp %h/%h/%h/%0d",
                         i, o_addr, o_be, o_rdata, o_cycles, e.addr, e.be, e.rdata, e.cycles);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ta [4];
        logic [2:0]  ts [4];
        exp_t e;
        ta = '{32'h101, 32'h102, 32'h0, 32'h3};
        ts = '{3'd1, 3'd2, 3'd3, 3'd1};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 3));
            do_xfer(ta[i], i[0], ts[i], 2'b10, 32'hFFFF, 0, 1'b0, 32'hBAD, 1'b0, 1'b0, 32'h0, 3'd0);
            e = sb.pop_front();
            tests_run++; if (o_req !== e.req) begin tests_failed++; $display("FAIL misalign[%0d].req got=%b exp=%b", i, o_req, e.req); end
            tests_run++; if (o_resp !== e.resp || o_err1 !== 1'b1 || o_cycles !== e.cycles || o_rdata !== e.rdata) begin
                tests_failed++;
                $display("FAIL misalign[%0d].resp resp=%b err1=%b cyc=%0d rdata=%h exp %b/1/%0d/%h",
                         i, o_resp, o_err1, o_cycles, o_rdata, e.resp, e.cycles, e.rdata);
            end
        end
    endtask

    task automatic test_obi_error();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            // read error then write error: both must look the same on AHB
            sb.push_back(mk(32'h400, 4'hF, i[0], 32'h0, 1'b1, 1'b1, 5));
            sb.push_back(mk(32'h404, 4'hF, 1'b0, 32'h600D0000 + i, 1'b0, 1'b1, 3));
            do_xfer(32'h400, i[0], 3'd2, 2'b10, 32'h77, 0, 1'b1, 32'hDEAD, 1'b0, 1'b1, 32'h404, 3'd2);
            e = sb.pop_front();
            tests_run++; if (o_resp !== e.resp || o_err1 !== 1'b1 || o_cycles !== e.cycles || o_rdata !== e.rdata) begin
                tests_failed++;
                $display("FAIL obi_err[%0d] resp=%b err1=%b cyc=%0d rdata=%h exp %b/1/%0d/%h",
                         i, o_resp, o_err1, o_cycles, o_rdata, e.resp, e.cycles, e.rdata);
            end
            do_xfer(32'h404, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h600D0000 + i, 1'b1, 1'b0, 32'h0, 3'd0);
            e = sb.pop_front();
            tests_run++; if (o_addr !== e.addr || o_resp !== e.resp || o_rdata !== e.rdata || o_cycles !== e.cycles) begin
                tests_failed++;
                $display("FAIL after_err[%0d] addr=%h resp=%b rdata=%h cyc=%0d exp %h/%b/%h/%0d",
                         i, o_addr, o_resp, o_rdata, o_cycles, e.addr, e.resp, e.rdata, e.cycles);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back(mk(32'h500, 4'hF, 1'b0, 32'h11112222, 1'b0, 1'b1, 3));
        sb.push_back(mk(32'h504, 4'hF, 1'b0, 32'h33334444, 1'b0, 1'b1, 3));
        do_xfer(32'h500, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h11112222, 1'b0, 1'b1, 32'h504, 3'd2);
        e = sb.pop_front();
        tests_run++; if (o_rdata !== e.rdata || o_cycles !== e.cycles) begin
            tests_failed++; $display("FAIL b2b.first rdata=%h cyc=%0d exp %h/%0d", o_rdata, o_cycles, e.rdata, e.cycles);
        end
        do_xfer(32'h504, 1'b0, 3'd2, 2'b10, 32'h0, 0, 1'b0, 32'h33334444, 1'b1, 1'b0, 32'h0, 3'd0);
        e = sb.pop_front();
        tests_run++; if (o_first_req !== 1'b1) begin tests_failed++; $display("FAIL b2b.req_rise got=%b exp=1", o_first_req); end
        tests_run++; if (o_addr !== e.addr || o_rdata !== e.rdata || o_cycles !== e.cycles) begin
            tests_failed++; $display("FAIL b2b.second addr=%h rdata=%h cyc=%0d exp %h/%h/%0d", o_addr, o_rdata, o_cycles, e.addr, e.rdata, e.cycles);
        end
    endtask

    task automatic test_reset_mid();
        hsel_s = 1'b1; haddr_s = 32'h300; htrans_s = 2'b10; hwrite_s = 1'b0; hsize_s = 3'd2;
        @(posedge hclk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; obi_gnt_i = 1'b1;
        @(posedge hclk); #1;
        obi_gnt_i = 1'b0;
        tests_run++; if (hreadyout_s !== 1'b0 || obi_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid.in_resp hreadyout=%b req=%b exp 0/0", hreadyout_s, obi_req_o);
        end
        #2 hreset_n = 1'b0;
        #1;
        tests_run++; if (hreadyout_s !== 1'b1 || hresp_s !== 1'b0 || obi_req_o !== 1'b0 || obi_addr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid.async hreadyout=%b hresp=%b req=%b addr=%h exp 1/0/0/0", hreadyout_s, hresp_s, obi_req_o, obi_addr_o);
        end
        @(negedge hclk); hreset_n = 1'b1;
        @(posedge hclk); #1;
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEADBEEF;
        @(negedge hclk);
        tests_run++; if (hrdata_s !== 32'h0 || hreadyout_s !== 1'b1 || hresp_s !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid.late_rvalid hrdata=%h hreadyout=%b hresp=%b exp 0/1/0", hrdata_s, hreadyout_s, hresp_s);
        end
        @(posedge hclk); #1;
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0;
        tests_run++; if (obi_req_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid.req got=%b exp=0", obi_req_o); end
    endtask

    initial begin
        test_reset();
        test_idle_busy();
        test_word_read();
        test_byte_write();
        test_lanes();
        test_misalign();
        test_obi_error();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
